pe_inj_arb: RTL and testbench

- Injection scheduler in front of the PE→switch injection port of a torus node.
- Shares the single injection channel (out_pkt/out_vld, sw_rdy accept) among N_REQ local packet sources in round-robin order.
- Holds the granted packet in an output register until the switch accepts it.
- Counts accepted packets for debug and performance use.

---
 rtl/pe_inj_arb.sv | 153 +++++++++++++++
 tb/tb_pe_inj_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_inj_arb.sv
`default_nettype none
// ============================================================================
// Module   : pe_inj_arb
// Brief    : Round-robin injection scheduler for the PE-to-switch port of a
//            torus node. Grants one of N_REQ local sources into a single
//            output register, holds it until the switch accepts it and
//            counts accepted packets.
// Options  : PE_INJ_RATE_LIMIT_EN - enforce rate_gap idle cycles after
//            every acceptance (gap counter is only built when defined).
// Revision : 1.0 - initial release
// ============================================================================
module pe_inj_arb #(
  parameter int P_W   = 16,
  parameter int N_REQ = 4,
  parameter int GAP_W = 4,
  parameter int CNT_W = 16,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ*P_W-1:0] req_pkt,
  input  logic [N_REQ-1:0]     req_vld,
  output logic [N_REQ-1:0]     req_rdy,
  output logic [P_W-1:0]       out_pkt,
  output logic                 out_vld,
  input  logic                 sw_rdy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic [CNT_W-1:0]     tx_cnt,
  input  logic [GAP_W-1:0]     rate_gap
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [P_W-1:0]     out_pkt_q, out_pkt_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;

  logic               w_found;
  logic [IDX_W-1:0]   w_gnt;
  logic               w_accept;
  logic               w_gap_ok;
  logic               w_load;

  // The register is "taken" by the switch only while it actually holds a packet.
  assign w_accept = (state_q == ST_HOLD) && sw_rdy;

`ifdef PE_INJ_RATE_LIMIT_EN
  logic [GAP_W-1:0] gap_q, gap_d;

  // The counter holds the idle cycles still owed after the current one, so an
  // acceptance loads rate_gap-1 and the acceptance cycle itself is blocked.
  always_comb begin
    gap_d = gap_q;
    if (w_accept) begin
      gap_d = (rate_gap == '0) ? '0 : rate_gap - GAP_W'(1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  // Gap counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign w_gap_ok = (gap_q == '0) && !(w_accept && (rate_gap != '0));
`else
  logic w_unused_rate_gap;
  assign w_unused_rate_gap = ^rate_gap;
  assign w_gap_ok          = 1'b1;
`endif

  // Round-robin search: first valid requester at or after the pointer. The
  // loop runs downward so the smallest offset from the pointer wins.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (req_vld[IDX_W'(j)]) begin
        w_found = 1'b1;
        w_gnt   = IDX_W'(j);
      end
    end
  end

  // Load when the register is free (or being freed this cycle) and the gap allows.
  assign w_load = w_found && ((state_q == ST_IDLE) || sw_rdy) && w_gap_ok;

  // Next-state and datapath: defaults hold everything, then load/accept override.
  always_comb begin
    state_d   = state_q;
    out_pkt_d = out_pkt_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    tx_cnt_d  = tx_cnt_q;
    req_rdy   = '0;

    if (w_accept) begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end

    if (w_load) begin
      req_rdy[w_gnt] = 1'b1;
      out_pkt_d      = req_pkt[int'(w_gnt)*P_W +: P_W];
      grant_d        = w_gnt;
      rr_d           = (w_gnt == c_LAST_IDX) ? '0 : w_gnt + IDX_W'(1);
      state_d        = ST_HOLD;
    end else if (w_accept) begin
      state_d = ST_IDLE;
    end
  end

  // State and datapath registers; reset drops any held packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      out_pkt_q <= '0;
      grant_q   <= '0;
      rr_q      <= '0;
      tx_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      out_pkt_q <= out_pkt_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      tx_cnt_q  <= tx_cnt_d;
    end
  end

  assign out_vld   = (state_q == ST_HOLD);
  assign out_pkt   = out_pkt_q;
  assign grant_idx = grant_q;
  assign tx_cnt    = tx_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_inj_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_inj_arb
// Brief    : Directed self-checking bench for pe_inj_arb (default parameters).
//            Rate-limit expectations follow PE_INJ_RATE_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_inj_arb;
  localparam int P_W   = 16;
  localparam int N_REQ = 4;
  localparam int GAP_W = 4;
  localparam int CNT_W = 16;

  logic                 clk;
  logic                 rst_n;
  logic [N_REQ*P_W-1:0] req_pkt;
  logic [N_REQ-1:0]     req_vld;
  logic [N_REQ-1:0]     req_rdy;
  logic [P_W-1:0]       out_pkt;
  logic                 out_vld;
  logic                 sw_rdy;
  logic [1:0]           grant_idx;
  logic [CNT_W-1:0]     tx_cnt;
  logic [GAP_W-1:0]     rate_gap;

  int n_chk;
  int n_err;

  pe_inj_arb #(.P_W(P_W), .N_REQ(N_REQ), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_pkt   (req_pkt),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .out_pkt   (out_pkt),
    .out_vld   (out_vld),
    .sw_rdy    (sw_rdy),
    .grant_idx (grant_idx),
    .tx_cnt    (tx_cnt),
    .rate_gap  (rate_gap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    req_vld  = '0;
    req_pkt  = '0;
    sw_rdy   = 1'b0;
    rate_gap = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] vld_pat;
    n_chk = 0;
    n_err = 0;
    rst_n    = 1'b0;
    req_vld  = '0;
    req_pkt  = '0;
    sw_rdy   = 1'b0;
    rate_gap = '0;
    #2;

    // Reset state
    chk("rst_out_vld", 32'(out_vld), 32'h0);
    chk("rst_out_pkt", 32'(out_pkt), 32'h0);
    chk("rst_grant", 32'(grant_idx), 32'h0);
    chk("rst_tx_cnt", 32'(tx_cnt), 32'h0);
    chk("rst_req_rdy", 32'(req_rdy), 32'h0);

    // Single requester, sw_rdy constant
    do_reset();
    req_pkt[15:0] = 16'hA5A5;
    req_vld       = 4'b0001;
    sw_rdy        = 1'b1;
    #1;
    chk("t1_rdy_c0", 32'(req_rdy), 32'h1);
    tick();
    chk("t1_vld_c1", 32'(out_vld), 32'h1);
    chk("t1_pkt_c1", 32'(out_pkt), 32'hA5A5);
    chk("t1_gnt_c1", 32'(grant_idx), 32'h0);
    chk("t1_cnt_c1", 32'(tx_cnt), 32'h0);
    tick();
    chk("t1_cnt_c2", 32'(tx_cnt), 32'h1);
    chk("t1_vld_c2", 32'(out_vld), 32'h1);
    req_vld = 4'b0000;
    tick();
    chk("t1_cnt_c3", 32'(tx_cnt), 32'h2);
    chk("t1_vld_c3", 32'(out_vld), 32'h0);
    chk("t1_pkt_hold", 32'(out_pkt), 32'hA5A5);

    // All requesters valid: 0,1,2,3,0,... with no bubbles
    do_reset();
    req_pkt = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    req_vld = 4'b1111;
    sw_rdy  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_gnt", 32'(grant_idx), 32'(k % 4));
      chk("t2_pkt", 32'(out_pkt), 32'h1000 + 32'(k % 4));
      chk("t2_vld", 32'(out_vld), 32'h1);
      chk("t2_cnt", 32'(tx_cnt), 32'(k));
    end
    tick();
    chk("t2_cnt8", 32'(tx_cnt), 32'h8);

    // Backpressure: held packet stays stable for 5 stalled cycles
    do_reset();
    req_pkt[31:16] = 16'h1234;
    req_vld        = 4'b0010;
    sw_rdy         = 1'b0;
    tick();
    chk("t3_gnt", 32'(grant_idx), 32'h1);
    req_pkt[31:16] = 16'h5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_pkt", 32'(out_pkt), 32'h1234);
      chk("t3_vld", 32'(out_vld), 32'h1);
      chk("t3_rdy", 32'(req_rdy), 32'h0);
      chk("t3_cnt", 32'(tx_cnt), 32'h0);
      if (i < 4) tick();
    end
    req_vld = 4'b0000;
    sw_rdy  = 1'b1;
    tick();
    chk("t3_cnt_acc", 32'(tx_cnt), 32'h1);
    chk("t3_vld_idle", 32'(out_vld), 32'h0);
    tick();
    chk("t3_cnt_ignored", 32'(tx_cnt), 32'h1);

    // Fairness: after granting 2, search starts at 3 and wraps to 0
    do_reset();
    req_pkt = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    req_vld = 4'b0100;
    sw_rdy  = 1'b1;
    #1;
    chk("t4_rdy_a", 32'(req_rdy), 32'h4);
    tick();
    chk("t4_gnt_a", 32'(grant_idx), 32'h2);
    req_vld = 4'b0101;
    #1;
    chk("t4_rdy_b", 32'(req_rdy), 32'h1);
    tick();
    chk("t4_gnt_b", 32'(grant_idx), 32'h0);
    chk("t4_pkt_b", 32'(out_pkt), 32'hD000);
    #1;
    chk("t4_rdy_c", 32'(req_rdy), 32'h4);
    tick();
    chk("t4_gnt_c", 32'(grant_idx), 32'h2);

    // Asynchronous reset while holding a packet
    do_reset();
    req_pkt[15:0] = 16'hBEEF;
    req_vld       = 4'b0001;
    sw_rdy        = 1'b1;
    tick();
    tick();
    sw_rdy = 1'b0;
    chk("t5_pre_vld", 32'(out_vld), 32'h1);
    chk("t5_pre_cnt", 32'(tx_cnt), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_vld", 32'(out_vld), 32'h0);
    chk("t5_async_cnt", 32'(tx_cnt), 32'h0);
    chk("t5_async_gnt", 32'(grant_idx), 32'h0);
    #1;
    rst_n   = 1'b1;
    req_vld = 4'b1111;
    #1;
    chk("t5_rr_restart", 32'(req_rdy), 32'h1);

    // Rate limiting (pattern depends on the build option)
    do_reset();
    req_pkt[15:0] = 16'h0C0C;
    rate_gap      = 4'd3;
    req_vld       = 4'b0001;
    sw_rdy        = 1'b1;
`ifdef PE_INJ_RATE_LIMIT_EN
    vld_pat = 9'b1_0001_0001;
`else
    vld_pat = 9'b1_1111_1111;
`endif
    for (int c = 0; c < 9; c++) begin
      tick();
      chk("t6_gap3_vld", 32'(out_vld), 32'(vld_pat[c]));
    end
    rate_gap = 4'd0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_gap0_vld", 32'(out_vld), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
